// File: rtl/fft_ctrl_if.sv
// Handshake and address bus between the FFT sequencer and its environment.
// The slave modport is the sequencer side; the master modport drives start, size and ready.
interface fft_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W:0]   fft_size;
  logic              cfg_err;
  logic              busy;
  logic              done;
  logic [2:0]        stage;
  logic              bf_valid;
  logic              bf_ready;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-2:0] tw_addr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr_a;
  logic [ADDR_W-1:0] wb_addr_b;

  modport master (
    output start, fft_size, bf_ready,
    input  cfg_err, busy, done, stage, bf_valid, addr_a, addr_b, tw_addr,
           wb_valid, wb_addr_a, wb_addr_b
  );

  modport slave (
    input  start, fft_size, bf_ready,
    output cfg_err, busy, done, stage, bf_valid, addr_a, addr_b, tw_addr,
           wb_valid, wb_addr_a, wb_addr_b
  );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues butterfly address pairs and twiddle indices
// stage by stage, and drains the butterfly pipeline between stages.
module fft_ctrl #(
  parameter int ADDR_W = 5,
  parameter int BF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  fft_ctrl_if.slave  bus
);
  localparam int JW = ADDR_W - 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int LW = 2 * ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      log_reg, log_next;
  logic [2:0]      stage_reg, stage_next;
  logic [JW-1:0]   j_reg, j_next;
  logic [DW-1:0]   drain_reg, drain_next;
  logic            cfg_err_reg, cfg_err_next;
  logic [LW-1:0]   dl_reg [BF_LAT];

  logic              size_legal;
  logic [2:0]        size_log;
  logic              run;
  logic              hs;
  logic              j_last;
  logic [ADDR_W-1:0] n_half;
  logic [ADDR_W-1:0] half, pos, grp, a_raw, b_raw;
  logic [ADDR_W-2:0] tw_raw;

  always_comb begin
    size_log = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      if (bus.fft_size[i]) size_log = 3'(i);
    end
  end

  // One-hot test plus the N >= 4 floor (bits 0 and 1 must be clear).
  assign size_legal = (bus.fft_size != '0) &&
                      ((bus.fft_size & (bus.fft_size - (ADDR_W+1)'(1))) == '0) &&
                      (bus.fft_size[1:0] == 2'b00);

  assign run    = (state_reg == RUN);
  assign hs     = run & bus.bf_ready;
  assign n_half = ADDR_W'(1) << (log_reg - 3'd1);
  assign j_last = ({1'b0, j_reg} == (n_half - ADDR_W'(1)));

  assign half   = ADDR_W'(1) << stage_reg;
  assign pos    = {1'b0, j_reg} & (half - ADDR_W'(1));
  assign grp    = {1'b0, j_reg} >> stage_reg;
  assign a_raw  = (grp << (stage_reg + 3'd1)) | pos;
  assign b_raw  = a_raw + half;
  // Shifting by the maximum-size exponent keeps the twiddle index independent of N.
  assign tw_raw = JW'(pos << (3'(ADDR_W - 1) - stage_reg));

  always_comb begin
    state_next   = state_reg;
    log_next     = log_reg;
    stage_next   = stage_reg;
    j_next       = j_reg;
    drain_next   = drain_reg;
    cfg_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (size_legal) begin
            state_next = RUN;
            log_next   = size_log;
            stage_next = '0;
            j_next     = '0;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (j_last) begin
            state_next = DRAIN;
            drain_next = DW'(BF_LAT - 1);
            j_next     = '0;
          end else begin
            j_next = j_reg + JW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_reg == '0) begin
          if (stage_reg == log_reg - 3'd1) begin
            state_next = DONE;
          end else begin
            stage_next = stage_reg + 3'd1;
            state_next = RUN;
          end
        end else begin
          drain_next = drain_reg - DW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      log_reg     <= '0;
      stage_reg   <= '0;
      j_reg       <= '0;
      drain_reg   <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      log_reg     <= log_next;
      stage_reg   <= stage_next;
      j_reg       <= j_next;
      drain_reg   <= drain_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  // Write-back delay line never stalls; it only mirrors the butterfly pipeline depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LAT; i++) dl_reg[i] <= '0;
    end else begin
      dl_reg[0] <= {hs, a_raw, b_raw};
      for (int i = 1; i < BF_LAT; i++) dl_reg[i] <= dl_reg[i-1];
    end
  end

  assign bus.cfg_err  = cfg_err_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.stage    = stage_reg;
  assign bus.bf_valid = run;
  assign bus.addr_a   = run ? a_raw  : '0;
  assign bus.addr_b   = run ? b_raw  : '0;
  assign bus.tw_addr  = run ? tw_raw : '0;
  assign {bus.wb_valid, bus.wb_addr_a, bus.wb_addr_b} = dl_reg[BF_LAT-1];
endmodule

// File: tb/tb_fft_ctrl.sv
// Directed/randomized bench for fft_ctrl: compares issue order, stalls, write-back
// timing and control pulses against a nested-loop butterfly model.
module tb_fft_ctrl;
  localparam int ADDR_W = 5;
  localparam int BF_LAT = 3;
  localparam int NMAX   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fft_ctrl #(.ADDR_W(ADDR_W), .BF_LAT(BF_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  bit hs_v [4096];
  int hs_a [4096];
  int hs_b [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),      0);
    chk({tag, "_done"},     32'(bus.done),      0);
    chk({tag, "_cfg_err"},  32'(bus.cfg_err),   0);
    chk({tag, "_bf_valid"}, 32'(bus.bf_valid),  0);
    chk({tag, "_stage"},    32'(bus.stage),     0);
    chk({tag, "_addr_a"},   32'(bus.addr_a),    0);
    chk({tag, "_addr_b"},   32'(bus.addr_b),    0);
    chk({tag, "_tw_addr"},  32'(bus.tw_addr),   0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid),  0);
    chk({tag, "_wb_a"},     32'(bus.wb_addr_a), 0);
    chk({tag, "_wb_b"},     32'(bus.wb_addr_b), 0);
  endtask

  // Runs one full transform of size n; rnd randomizes bf_ready; alt_size != 0 injects
  // a competing start request mid-run.
  task automatic run_fft(input int n, input bit rnd, input int alt_size);
    int lg, half_n, total, k, idle, wb_cnt, done_cyc, cyc;
    int ea[$], eb[$], et[$];
    bit prev_stall, exp_wb;
    int pa, pb, pt, ps;
    lg = $clog2(n);
    half_n = n / 2;
    total = lg * half_n;
    for (int s = 0; s < lg; s++) begin
      int span = 1 << s;
      for (int base = 0; base < n; base += 2 * span) begin
        for (int m = 0; m < span; m++) begin
          ea.push_back(base + m);
          eb.push_back(base + m + span);
          et.push_back(m * ((NMAX / 2) >> s));
        end
      end
    end
    for (int i = 0; i < 4096; i++) hs_v[i] = 1'b0;

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.fft_size = (ADDR_W+1)'(n);
    bus.bf_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;

    k = 0; idle = 0; wb_cnt = 0; done_cyc = -1; prev_stall = 1'b0;
    pa = 0; pb = 0; pt = 0; ps = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      bus.bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (alt_size != 0 && cyc == 10) begin
        bus.start = 1'b1;
        bus.fft_size = (ADDR_W+1)'(alt_size);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) chk("first_issue", 32'(bus.bf_valid), 1);
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.bf_valid), 1);
        chk("hold_a", 32'(bus.addr_a), pa);
        chk("hold_b", 32'(bus.addr_b), pb);
        chk("hold_tw", 32'(bus.tw_addr), pt);
        chk("hold_stage", 32'(bus.stage), ps);
      end
      if (bus.bf_valid) begin
        if (!rnd && idle > 0 && k > 0) chk("stage_gap", idle, BF_LAT);
        idle = 0;
        if (bus.bf_ready) begin
          if (k < total) begin
            chk("issue_a", 32'(bus.addr_a), ea[k]);
            chk("issue_b", 32'(bus.addr_b), eb[k]);
            chk("issue_tw", 32'(bus.tw_addr), et[k]);
            chk("issue_stage", 32'(bus.stage), k / half_n);
            hs_v[cyc] = 1'b1;
            hs_a[cyc] = int'(bus.addr_a);
            hs_b[cyc] = int'(bus.addr_b);
          end else begin
            chk("extra_issue", k, total - 1);
          end
          k++;
        end
      end else begin
        idle++;
      end
      prev_stall = bus.bf_valid && !bus.bf_ready;
      pa = int'(bus.addr_a); pb = int'(bus.addr_b);
      pt = int'(bus.tw_addr); ps = int'(bus.stage);
      exp_wb = (cyc >= BF_LAT) && hs_v[cyc - BF_LAT];
      chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wb));
      if (exp_wb) begin
        chk("wb_addr_a", 32'(bus.wb_addr_a), hs_a[cyc - BF_LAT]);
        chk("wb_addr_b", 32'(bus.wb_addr_b), hs_b[cyc - BF_LAT]);
        wb_cnt++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(done_cyc >= 0), 1);
    if (!rnd) chk("done_cycle", done_cyc, lg * (half_n + BF_LAT));
    chk("hs_count", k, total);
    chk("wb_count", wb_cnt, total);
    $display("run N=%0d rnd=%0d alt=%0d: handshakes=%0d writebacks=%0d done_cycle=%0d",
             n, rnd, alt_size, k, wb_cnt, done_cyc);
  endtask

  task automatic illegal(input logic [ADDR_W:0] sz);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.fft_size = sz;
    bus.bf_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", 32'(bus.cfg_err), 1);
    chk("cfg_err_busy", 32'(bus.busy), 0);
    chk("cfg_err_valid", 32'(bus.bf_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_err_clear", 32'(bus.cfg_err), 0);
    chk("cfg_err_idle", 32'(bus.busy), 0);
    chk("cfg_err_novalid", 32'(bus.bf_valid), 0);
    $display("illegal fft_size=%b: cfg_err=pulse busy=%0d", sz, bus.busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.fft_size = '0;
    bus.bf_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    $display("reset: outputs checked");
    @(posedge clk); #1;
    rst_n = 1'b1;

    illegal(6'b000011);
    illegal(6'b000000);
    illegal(6'b000010);

    run_fft(8, 1'b0, 0);
    run_fft(32, 1'b0, 0);
    run_fft(4, 1'b0, 0);
    run_fft(16, 1'b1, 0);
    run_fft(32, 1'b0, 8);

    // Reset during the stage-2 drain of a 32-point transform.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.fft_size = 6'b100000;
    bus.bf_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (55) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_drain", 32'(bus.bf_valid), 0);
    chk("pre_reset_stage", 32'(bus.stage), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_wb", 32'(bus.wb_valid), 0);
      chk("post_reset_busy", 32'(bus.busy), 0);
      @(posedge clk); #1;
    end
    $display("reset mid-run: outputs cleared, no stray write-back");

    run_fft(32, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Sequencer for the in-place radix-2 DIT FFT datapath. On `start`, it walks all log2(N) stages of an N-point transform, where N is given as a one-hot `fft_size`. For every butterfly it issues the operand address pair and twiddle index to the butterfly unit and shared data RAM. It also carries the write-back addresses through a delay line matched to the butterfly pipeline. Between stages it stalls until the pipeline has drained, so no stage reads data that has not yet been written back.

## Interface
- `ADDR_W`, 5 — data RAM address width; maximum N = 2^ADDR_W.
- `BF_LAT`, 3 — butterfly latency in cycles from issue handshake to write-back (≥1).
- `clk` in 1 — clock, rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `start` in 1 — start request; sampled only in IDLE.
- `fft_size` in ADDR_W+1 — one-hot N (e.g. 6'b100000 = 32); sampled with `start`.
- `cfg_err` out 1 — one-cycle pulse when `start` arrives with an illegal `fft_size`.
- `busy` out 1 — high in RUN, DRAIN and DONE.
- `done` out 1 — one-cycle pulse when the transform is complete.
- `stage` out 3 — current stage index s.
- `bf_valid` out 1 — butterfly issue valid.
- `bf_ready` in 1 — butterfly unit / RAM port accepts the issue.
- `addr_a`, `addr_b` out ADDR_W — operand addresses.
- `tw_addr` out ADDR_W-1 — twiddle ROM index; the ROM holds W_Nmax^k for k in 0..Nmax/2-1.
- `wb_valid` out 1 — write-back strobe, delayed BF_LAT cycles after the issue handshake.
- `wb_addr_a`, `wb_addr_b` out ADDR_W — write-back addresses, delayed with `wb_valid`.

## Operation
- **Legal `fft_size`:** exactly one bit set and N ≥ 4. Anything else with `start` in IDLE produces a `cfg_err` pulse; the block stays in IDLE.
- **IDLE → RUN:** on `start` with a legal size. Latch L = log2(N), set s=0, j=0.
- **RUN:**
  - `bf_valid`=1.
  - Handshake = `bf_valid` & `bf_ready`; each handshake increments j.
  - On the handshake with j = N/2-1: go to DRAIN and load drain counter = BF_LAT-1.
  - While `bf_ready`=0, all outputs hold steady.
- **DRAIN:**
  - `bf_valid`=0; the counter decrements each cycle.
  - At 0 with s = L-1: go to DONE.
  - At 0 otherwise: s+1, j=0, go to RUN.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- **Address generation** (all unsigned, ADDR_W wide, no overflow for legal N):
  - half = 1<<s; pos = j & (half-1); grp = j>>s.
  - `addr_a` = (grp<<(s+1)) | pos.
  - `addr_b` = `addr_a` + half.
  - `tw_addr` = pos << (ADDR_W-1-s). This makes the twiddle index independent of N.
- **Write-back delay line:**
  - BF_LAT-deep shift register of {handshake, `addr_a`, `addr_b`}.
  - Shifts every cycle, with no stall.
  - `wb_valid` is the delayed handshake bit.
- **Reset (`rst_n`=0 at any edge, including mid-run):**
  - Go to IDLE.
  - All outputs 0: `busy`, `done`, `cfg_err`, `bf_valid`, `stage`, `addr_a`, `addr_b`, `tw_addr`, `wb_*`.
  - The delay line is cleared; no stray `wb_valid` after reset.

## Timing
- **`start` to first issue:** `start` sampled at edge t0 → `bf_valid`=1 in the cycle after t0.
- **Stage boundary:** last handshake of a stage in cycle t → `wb_valid` for it in cycle t+BF_LAT → DRAIN occupies cycles t+1..t+BF_LAT → first issue of the next stage in cycle t+BF_LAT+1.
- **`done`:** asserted in the cycle after the final DRAIN. By then the last write-back has completed.
- **Cycle count with `bf_ready` held 1:**
  - From first RUN cycle to `done`: L·(N/2 + BF_LAT) cycles, then `done`.
  - N=32, BF_LAT=3 → 95 cycles.
- **`cfg_err`:** asserted in the cycle after the illegal `start`.
- **Back-to-back:** a new `start` is accepted in the cycle after `done` (IDLE).

## Test plan
- **N=8, BF_LAT=3, `bf_ready`=1.** Required issue sequence (`addr_a`,`addr_b`,`tw_addr`):
  - s0: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - s1: (0,2,0) (1,3,8) (4,6,0) (5,7,8).
  - s2: (0,4,0) (1,5,4) (2,6,8) (3,7,12).
  - `done` 3·(4+3) cycles after the first issue; each stage separated by exactly 3 idle `bf_valid` cycles.
- **N=32, `bf_ready`=1.**
  - 80 handshakes and 80 `wb_valid` pulses, each `wb_addr` equal to the issue address 3 cycles earlier.
  - `done` at cycle 95; `stage` steps 0→4.
- **`bf_ready` toggled pseudo-randomly, N=16.**
  - Addresses and `tw_addr` held stable while stalled.
  - Issue sequence identical to the unstalled run; 32 handshakes total.
- **Illegal sizes:** `fft_size` = 6'b000011, 6'b000000 and 6'b000010 with `start` → each gives a `cfg_err` pulse, `busy` stays 0, no `bf_valid`.
- **Reset mid-run:**
  - Assert `rst_n`=0 during stage 2 DRAIN of N=32 → next cycle all outputs 0 and `wb_valid` stays 0.
  - A subsequent `start` runs a clean full transform.
- **`start` while busy:** pulse `start` with a different `fft_size` mid-run → ignored; the transform completes with the original N.
